gwa_payout: RTL and testbench
=============================

# gwa_payout

Coin payout controller for the money-changer design: the consumer end of the changer FSM's return commands. It accepts one-cycle return pulses (ten 10-cent coins, twenty 10-cent coins, one 1-euro coin, one 2-euro coin) and queues them as per-denomination pending counts. It then drives the three ejector solenoids one coin at a time, confirming each coin with its drop sensor and detecting jams by timeout.

## Interface
Parameters:
- PULSE_W, 4: ejector active width in cycles (>=1).
- TIMEOUT, 64: maximum cycles in WAIT for the drop sensor (>=1).
- CNT_W, 6: width of the 10-cent pending counter. 1-euro and 2-euro counters are fixed at 4 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- c10_req  in  1  pulse: add 10 to the 10-cent pending count.
- c20_req  in  1  pulse: add 20 to the 10-cent pending count.
- eu1_req  in  1  pulse: add 1 to the 1-euro pending count.
- eu2_req  in  1  pulse: add 1 to the 2-euro pending count.
- sens_10c / sens_1e / sens_2e  in  1 each  synchronous one-cycle drop pulse per coin.
- ej_10c / ej_1e / ej_2e  out  1 each  ejector solenoid drive.
- pend_10c  out  CNT_W  pending 10-cent coins.
- busy  out  1  state != IDLE, or any pending count nonzero.
- ovf  out  1  sticky: a request was clipped by saturation.
- fault  out  1  sticky: jam detected; block halted.

## Operation
Reset:
- All counters are 0, state is IDLE, and every output is 0.
- Asynchronous assertion drops the ejectors immediately, including mid-pulse.

Request accumulation (every cycle except in FAULT):
- pend_10c += 10·c10_req + 20·c20_req, so simultaneous requests add 30.
- pend_1e += eu1_req.
- pend_2e += eu2_req.
- Saturating arithmetic: a sum exceeding the counter maximum clips to the maximum and sets ovf.
- An increment and a completion decrement in the same cycle are both applied.

FSM states: IDLE, EJECT, WAIT, FAULT.
- IDLE: if any count is nonzero, latch sel by priority 2e > 1e > 10c, clear the timer, and go to EJECT. Otherwise stay in IDLE.
- EJECT: ej_<sel> = 1 for exactly PULSE_W cycles, then go to WAIT.
- WAIT: all ejectors are 0 and the timer counts. When the timer reaches TIMEOUT without a sensor pulse, go to FAULT.
- Completion: a sens_<sel> pulse in EJECT or WAIT decrements the pending count of sel by 1 and returns the FSM to IDLE on the next edge. The ejector drops with the state change.
- Sensor pulses for a non-selected denomination, or any sensor pulse in IDLE, are ignored.
- FAULT: fault = 1, ejectors are 0, and requests are ignored. Only rst exits this state.
- Outputs are decoded from registered state, so they are glitch-free. At most one ejector is active at any time.

## Timing
- Latency: a request sampled at edge k makes pend nonzero after edge k; EJECT is entered at edge k+1, so ej is high one cycle after the pend update.
- Back-to-back coins: completion at edge m returns to IDLE; the next EJECT starts at edge m+1. The minimum gap between ejector pulses is 1 cycle.
- Worst-case time per coin without a fault: 1 + PULSE_W + TIMEOUT cycles.
- Priority is re-evaluated only in IDLE. A 2-euro request arriving mid-coin does not preempt the coin in progress.

## Configuration
- GWA_PAYOUT_RETRY_EN defined: on the first timeout for a coin, return to EJECT with the same sel and the timer cleared, then fire a second PULSE_W pulse. A second timeout for that coin enters FAULT. The retry flag clears on completion.
- GWA_PAYOUT_RETRY_EN undefined: the first timeout enters FAULT directly.

## Test plan
- Reset, then pulse c10_req once, with sens_10c pulsed 2 cycles into each WAIT. Required: exactly 10 ej_10c pulses of PULSE_W=4 cycles, then pend_10c=0, busy=0, fault=0.
- c10_req and c20_req in the same cycle. Required: pend_10c=30 on the next cycle, ovf=0.
- eu1_req, eu2_req and c10_req together. Required: ej_2e first, then ej_1e, then 10 ej_10c pulses; never two ejectors high at once.
- Raise pend_10c to 60 with CNT_W=6, then issue c20_req. Required: pend_10c=63 and ovf=1 (sticky).
- eu2_req with no sensor response, TIMEOUT=64. Required: fault=1 exactly 64 WAIT cycles after the ejector drops, ej_2e stays 0, and later requests are ignored. With GWA_PAYOUT_RETRY_EN: two ej_2e pulses precede the fault.
- Assert rst during the EJECT of a 1-euro coin. Required: ej_1e falls without waiting for a clock, all counts are 0, fault=0 and ovf=0.

Source files
------------

// File: rtl/gwa_payout.sv
// gwa_payout -- coin payout controller for the money-changer.
//
// Accepts one-cycle return pulses from the changer FSM and queues them as
// per-denomination pending counts (10-cent, 1-euro, 2-euro). Coins are paid
// out one at a time: the selected ejector is driven for PULSE_W cycles, then
// the block waits for that coin's drop sensor. A missing sensor pulse is
// treated as a jam, and the block halts in FAULT until rst.
//
// Ports:
//   clk, rst                     clock (rising edge), async active-high reset
//   c10_req / c20_req            pulse: +10 / +20 ten-cent coins
//   eu1_req / eu2_req            pulse: +1 one-euro / +1 two-euro coin
//   sens_10c / sens_1e / sens_2e one-cycle drop pulse per coin
//   ej_10c / ej_1e / ej_2e       ejector solenoid drive (at most one high)
//   pend_10c [CNT_W]             pending 10-cent coins
//   busy                         not idle, or coins still pending
//   ovf                          sticky: a request was clipped by saturation
//   fault                        sticky: jam detected, block halted
//
// Build option: define GWA_PAYOUT_RETRY_EN to fire one extra ejector pulse
// after the first timeout of a coin before declaring a jam.
module gwa_payout #(
  parameter int PULSE_W = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c10_req,
  input  logic             c20_req,
  input  logic             eu1_req,
  input  logic             eu2_req,
  input  logic             sens_10c,
  input  logic             sens_1e,
  input  logic             sens_2e,
  output logic             ej_10c,
  output logic             ej_1e,
  output logic             ej_2e,
  output logic [CNT_W-1:0] pend_10c,
  output logic             busy,
  output logic             ovf,
  output logic             fault
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EJECT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [1:0] SEL_10C = 2'd0;
  localparam logic [1:0] SEL_1E  = 2'd1;
  localparam logic [1:0] SEL_2E  = 2'd2;

  // One timer serves both the pulse width and the sensor timeout.
  localparam int TMAX = (TIMEOUT > PULSE_W) ? TIMEOUT : PULSE_W;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] PULSE_LAST   = TW'(PULSE_W - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  // Headroom for pend + 30 before clipping.
  localparam int SW = CNT_W + 5;
  localparam logic [SW-1:0] MAX10 = {5'b00000, {CNT_W{1'b1}}};

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [CNT_W-1:0] pend_10c_q, pend_10c_d;
  logic [3:0]       pend_1e_q, pend_1e_d;
  logic [3:0]       pend_2e_q, pend_2e_d;
  logic             ovf_q, ovf_d;
  logic             done_s;
  logic             sens_sel_s;
  logic             dec10_s, dec1_s, dec2_s;
  logic [SW-1:0]    sum10_s;
  logic [4:0]       sum1_s, sum2_s;
`ifdef GWA_PAYOUT_RETRY_EN
  logic             retry_q, retry_d;
`endif

  // Select the drop sensor of the coin currently being paid out.
  always_comb begin
    case (sel_q)
      SEL_2E:  sens_sel_s = sens_2e;
      SEL_1E:  sens_sel_s = sens_1e;
      SEL_10C: sens_sel_s = sens_10c;
      default: sens_sel_s = 1'b0;
    endcase
  end

  // FSM state register: state, selected denomination, timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_10C;
      tmr_q   <= '0;
`ifdef GWA_PAYOUT_RETRY_EN
      retry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tmr_q   <= tmr_d;
`ifdef GWA_PAYOUT_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  // FSM next-state logic. Priority is evaluated only in IDLE, so a late
  // high-value request never preempts the coin in flight.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tmr_d   = tmr_q;
    done_s  = 1'b0;
`ifdef GWA_PAYOUT_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
`ifdef GWA_PAYOUT_RETRY_EN
        // Every coin starts with its retry still available.
        retry_d = 1'b0;
`endif
        if (pend_2e_q != 4'd0) begin
          sel_d   = SEL_2E;
          state_d = ST_EJECT;
        end else if (pend_1e_q != 4'd0) begin
          sel_d   = SEL_1E;
          state_d = ST_EJECT;
        end else if (pend_10c_q != '0) begin
          sel_d   = SEL_10C;
          state_d = ST_EJECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EJECT: begin
        if (sens_sel_s) begin
          done_s  = 1'b1;
          state_d = ST_IDLE;
        end else if (tmr_q == PULSE_LAST) begin
          tmr_d   = '0;
          state_d = ST_WAIT;
        end else begin
          tmr_d = tmr_q + TW'(1'b1);
        end
      end
      ST_WAIT: begin
        if (sens_sel_s) begin
          done_s  = 1'b1;
          state_d = ST_IDLE;
        end else if (tmr_q == TIMEOUT_LAST) begin
`ifdef GWA_PAYOUT_RETRY_EN
          if (!retry_q) begin
            retry_d = 1'b1;
            tmr_d   = '0;
            state_d = ST_EJECT;
          end else begin
            state_d = ST_FAULT;
          end
`else
          state_d = ST_FAULT;
`endif
        end else begin
          tmr_d = tmr_q + TW'(1'b1);
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  // Pending counters: saturating add of requests minus a completed coin.
  // The decrement cannot underflow: a coin is only selected when its count
  // is nonzero, and nothing else lowers the count.
  always_comb begin
    dec10_s = done_s && (sel_q == SEL_10C);
    dec1_s  = done_s && (sel_q == SEL_1E);
    dec2_s  = done_s && (sel_q == SEL_2E);
    sum10_s = SW'(pend_10c_q)
            + (c10_req ? SW'(5'd10) : SW'(5'd0))
            + (c20_req ? SW'(5'd20) : SW'(5'd0))
            - SW'(dec10_s);
    sum1_s  = {1'b0, pend_1e_q} + {4'd0, eu1_req} - {4'd0, dec1_s};
    sum2_s  = {1'b0, pend_2e_q} + {4'd0, eu2_req} - {4'd0, dec2_s};
    pend_10c_d = pend_10c_q;
    pend_1e_d  = pend_1e_q;
    pend_2e_d  = pend_2e_q;
    ovf_d      = ovf_q;
    if (state_q != ST_FAULT) begin
      if (sum10_s > MAX10) begin
        pend_10c_d = {CNT_W{1'b1}};
        ovf_d      = 1'b1;
      end else begin
        pend_10c_d = sum10_s[CNT_W-1:0];
      end
      if (sum1_s > 5'd15) begin
        pend_1e_d = 4'd15;
        ovf_d     = 1'b1;
      end else begin
        pend_1e_d = sum1_s[3:0];
      end
      if (sum2_s > 5'd15) begin
        pend_2e_d = 4'd15;
        ovf_d     = 1'b1;
      end else begin
        pend_2e_d = sum2_s[3:0];
      end
    end else begin
      // Halted: requests are dropped, counts frozen.
      pend_10c_d = pend_10c_q;
      pend_1e_d  = pend_1e_q;
      pend_2e_d  = pend_2e_q;
    end
  end

  // Pending-count and overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_10c_q <= '0;
      pend_1e_q  <= 4'd0;
      pend_2e_q  <= 4'd0;
      ovf_q      <= 1'b0;
    end else begin
      pend_10c_q <= pend_10c_d;
      pend_1e_q  <= pend_1e_d;
      pend_2e_q  <= pend_2e_d;
      ovf_q      <= ovf_d;
    end
  end

  // Output decode from registered state only; rst clears ejectors at once.
  always_comb begin
    ej_10c = 1'b0;
    ej_1e  = 1'b0;
    ej_2e  = 1'b0;
    if (state_q == ST_EJECT) begin
      case (sel_q)
        SEL_10C: ej_10c = 1'b1;
        SEL_1E:  ej_1e  = 1'b1;
        SEL_2E:  ej_2e  = 1'b1;
        default: ej_10c = 1'b0;
      endcase
    end else begin
      ej_10c = 1'b0;
    end
    pend_10c = pend_10c_q;
    busy     = (state_q != ST_IDLE) || (pend_10c_q != '0) ||
               (pend_1e_q != 4'd0) || (pend_2e_q != 4'd0);
    ovf      = ovf_q;
    fault    = (state_q == ST_FAULT);
  end

endmodule

// File: tb/tb_gwa_payout.sv
module tb_gwa_payout;
  localparam int PULSE_W = 4;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 6;
  localparam int MAX10   = (1 << CNT_W) - 1;
  localparam int MAXE    = 15;
`ifdef GWA_PAYOUT_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif
  // Reference-model phases of the coin in progress.
  localparam int PH_IDLE = 0, PH_PULSE = 1, PH_LISTEN = 2, PH_JAM = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic c10_req = 1'b0, c20_req = 1'b0, eu1_req = 1'b0, eu2_req = 1'b0;
  logic sens_10c = 1'b0, sens_1e = 1'b0, sens_2e = 1'b0;
  logic ej_10c, ej_1e, ej_2e, busy, ovf, fault;
  logic [CNT_W-1:0] pend_10c;

  gwa_payout #(.PULSE_W(PULSE_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .c10_req(c10_req), .c20_req(c20_req), .eu1_req(eu1_req), .eu2_req(eu2_req),
    .sens_10c(sens_10c), .sens_1e(sens_1e), .sens_2e(sens_2e),
    .ej_10c(ej_10c), .ej_1e(ej_1e), .ej_2e(ej_2e),
    .pend_10c(pend_10c), .busy(busy), .ovf(ovf), .fault(fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: coin counts per denomination (0=10c, 1=1e, 2=2e).
  int m_cnt[3];
  int m_ph, m_cur, m_age, m_tries, m_since, m_delay;
  bit m_ovf;
  // Sensor responder settings.
  int resp_fixed;
  bit resp_rand, noise, exact_width;
  // Ejector monitor.
  logic [2:0] prev_ej;
  logic prev_fault;
  int width[3], rises[3];
  int order[$];
  int fall_cyc, fault_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) m_cnt[d] = 0;
    m_ph = PH_IDLE; m_cur = 0; m_age = 0; m_tries = 0; m_since = 0; m_delay = -1;
    m_ovf = 1'b0;
  endtask

  task automatic clear_monitor();
    prev_ej = 3'b000; prev_fault = 1'b0;
    for (int d = 0; d < 3; d++) begin width[d] = 0; rises[d] = 0; end
    order.delete();
    fall_cyc = -1; fault_cyc = -1;
  endtask

  // Advance the model by one clock edge given the sampled inputs.
  task automatic model_update(input bit r10, input bit r20, input bit r1, input bit r2,
                              input bit [2:0] s);
    bit done, picked;
    int cur_old, n, lim;
    int add[3];
    cur_old = m_cur;
    done = (m_ph == PH_PULSE || m_ph == PH_LISTEN) && s[m_cur];
    add[0] = (r10 ? 10 : 0) + (r20 ? 20 : 0);
    add[1] = r1 ? 1 : 0;
    add[2] = r2 ? 1 : 0;
    // Counts first (they use the phase before this edge).
    if (m_ph != PH_JAM) begin
      for (int d = 0; d < 3; d++) begin
        n = m_cnt[d] + add[d] - ((done && cur_old == d) ? 1 : 0);
        lim = (d == 0) ? MAX10 : MAXE;
        if (n > lim) begin n = lim; m_ovf = 1'b1; end
        m_cnt[d] = n;
      end
    end
    case (m_ph)
      PH_IDLE: begin
        picked = 1'b0;
        for (int d = 2; d >= 0; d--) begin
          if (!picked && (m_cnt[d] - add[d]) > 0) begin
            picked = 1'b1; m_cur = d;
          end
        end
        if (picked) begin
          m_ph = PH_PULSE; m_age = 0; m_tries = 1; m_since = 0;
          m_delay = resp_rand ? int'($urandom_range(0, PULSE_W + 12)) : resp_fixed;
        end
      end
      PH_PULSE, PH_LISTEN: begin
        if (done) m_ph = PH_IDLE;
        else begin
          m_age++; m_since++;
          if (m_ph == PH_PULSE && m_age == PULSE_W) begin
            m_ph = PH_LISTEN; m_age = 0;
          end else if (m_ph == PH_LISTEN && m_age == TIMEOUT) begin
            if (RETRY && m_tries == 1) begin m_ph = PH_PULSE; m_age = 0; m_tries = 2; end
            else m_ph = PH_JAM;
          end
        end
      end
      default: ;
    endcase
  endtask

  // One clock: drive inputs, model the edge, compare all outputs on negedge.
  task automatic step(input bit r10, input bit r20, input bit r1, input bit r2);
    bit [2:0] s;
    bit inflight;
    logic [2:0] ejv, ejm;
    logic [11:0] exp_v, obs_v;
    s = 3'b000;
    inflight = (m_ph == PH_PULSE || m_ph == PH_LISTEN);
    if (inflight && m_since == m_delay) s[m_cur] = 1'b1;
    for (int d = 0; d < 3; d++)
      if (noise && $urandom_range(0, 15) == 0 && !(inflight && d == m_cur)) s[d] = 1'b1;
    c10_req = r10; c20_req = r20; eu1_req = r1; eu2_req = r2;
    sens_10c = s[0]; sens_1e = s[1]; sens_2e = s[2];
    @(posedge clk);
    model_update(r10, r20, r1, r2, s);
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 3; d++) ejm[d] = (m_ph == PH_PULSE && m_cur == d);
    exp_v = {ejm, CNT_W'(m_cnt[0]),
             (m_ph != PH_IDLE) || (m_cnt[0] + m_cnt[1] + m_cnt[2] != 0),
             m_ovf, (m_ph == PH_JAM)};
    ejv = {ej_2e, ej_1e, ej_10c};
    obs_v = {ejv, pend_10c, busy, ovf, fault};
    chk("outputs_vs_model", 32'(obs_v), 32'(exp_v));
    chk("one_ejector", 32'($countones(ejv) <= 1), 32'd1);
    for (int d = 0; d < 3; d++) begin
      if (ejv[d] && !prev_ej[d]) begin rises[d]++; order.push_back(d); width[d] = 0; end
      if (ejv[d]) width[d]++;
      if (!ejv[d] && prev_ej[d]) begin
        fall_cyc = cyc;
        if (exact_width) chk("pulse_width", 32'(width[d]), 32'(PULSE_W));
        else chk("pulse_width_max", 32'(width[d] <= PULSE_W), 32'd1);
      end
    end
    if (fault && !prev_fault) fault_cyc = cyc;
    prev_ej = ejv; prev_fault = fault;
  endtask

  task automatic do_reset();
    c10_req = 1'b0; c20_req = 1'b0; eu1_req = 1'b0; eu2_req = 1'b0;
    sens_10c = 1'b0; sens_1e = 1'b0; sens_2e = 1'b0;
    rst = 1'b1;
    model_reset();
    clear_monitor();
    repeat (2) @(negedge clk);
    chk("reset_state", 32'({ej_2e, ej_1e, ej_10c, pend_10c, busy, ovf, fault}), 32'd0);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget && busy !== 1'b0; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int zeros;
    noise = 1'b0; resp_rand = 1'b0; exact_width = 1'b1; resp_fixed = PULSE_W + 2;
    model_reset();
    clear_monitor();
    do_reset();

    // Ten 10-cent coins, sensor two cycles into each WAIT.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle(300, "t1_drain");
    chk("t1_rises", 32'(rises[0]), 32'd10);
    chk("t1_pend", 32'(pend_10c), 32'd0);
    chk("t1_fault", 32'(fault), 32'd0);

    // Simultaneous 10+20.
    clear_monitor();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t2_pend30", 32'(pend_10c), 32'd30);
    chk("t2_ovf", 32'(ovf), 32'd0);
    wait_idle(600, "t2_drain");
    chk("t2_rises", 32'(rises[0]), 32'd30);

    // Priority: 2e, then 1e, then ten 10c.
    clear_monitor();
    step(1'b1, 1'b0, 1'b1, 1'b1);
    wait_idle(400, "t3_drain");
    chk("t3_count", 32'(order.size()), 32'd12);
    if (order.size() == 12) begin
      chk("t3_first_2e", 32'(order[0]), 32'd2);
      chk("t3_then_1e", 32'(order[1]), 32'd1);
      zeros = 0;
      for (int i = 2; i < 12; i++) if (order[i] == 0) zeros++;
      chk("t3_then_10c", 32'(zeros), 32'd10);
    end

    // Saturation: 60 then +20 clips to 63, ovf sticky.
    do_reset();
    resp_fixed = 40;
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_pend60", 32'(pend_10c), 32'd60);
    chk("t4_ovf0", 32'(ovf), 32'd0);
    resp_fixed = PULSE_W + 2;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_pend63", 32'(pend_10c), 32'd63);
    chk("t4_ovf1", 32'(ovf), 32'd1);
    wait_idle(1500, "t4_drain");
    chk("t4_rises", 32'(rises[0]), 32'd63);
    chk("t4_ovf_sticky", 32'(ovf), 32'd1);

    // Jam: no sensor response to a 2-euro coin.
    do_reset();
    resp_fixed = -1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 400 && fault !== 1'b1; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_fault", 32'(fault), 32'd1);
    chk("t5_gap", 32'(fault_cyc - fall_cyc), 32'(TIMEOUT));
    chk("t5_pulses", 32'(rises[2]), RETRY ? 32'd2 : 32'd1);
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t5_ignored", 32'(pend_10c), 32'd0);
    chk("t5_ej_off", 32'({ej_2e, ej_1e, ej_10c}), 32'd0);
    chk("t5_fault_sticky", 32'(fault), 32'd1);

    // Asynchronous reset in the middle of a 1-euro pulse.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t6_ej1e_on", 32'(ej_1e), 32'd1);
    chk("t6_ovf_on", 32'(ovf), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_ej1e_async", 32'(ej_1e), 32'd0);
    chk("t6_pend", 32'(pend_10c), 32'd0);
    chk("t6_ovf", 32'(ovf), 32'd0);
    chk("t6_fault", 32'(fault), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    model_reset();
    clear_monitor();
    @(negedge clk);
    rst = 1'b0;

    // Random requests, random sensor delays, spurious sensor pulses.
    resp_rand = 1'b1; noise = 1'b1; exact_width = 1'b0;
    repeat (400) step($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
                      $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0);
    noise = 1'b0;
    wait_idle(3000, "t7_drain");
    chk("t7_fault", 32'(fault), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
